// File: rtl/tbird_light_seq.sv
// tbird_light_seq: prescaled Moore sequencer for Thunderbird turn/hazard tail lamps
module tbird_light_seq #(
  parameter int TICK_DIV = 101,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  output logic [2:0] lights_l,
  output logic [2:0] lights_r,
  output logic       busy,
  output logic       tick
);
  typedef enum logic [2:0] {IDLE, L1, L2, L3, R1, R2, R3, HAZ} state_t;
  state_t st, st_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0] l_n, r_n;
  logic ovr;
  assign tick = cnt == CNT_W'(TICK_DIV - 1);
  assign ovr = hazard | (left & right);
  // free-running prescaler, wraps on the strobe
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  // next state is evaluated only on strobe cycles; hazard or both turns override a running sequence
  always_comb begin
    st_n = st;
    if (tick)
      case (st)
        IDLE:    st_n = ovr ? HAZ : left ? L1 : right ? R1 : IDLE;
        L1:      st_n = ovr ? HAZ : L2;
        L2:      st_n = ovr ? HAZ : L3;
        L3:      st_n = ovr ? HAZ : IDLE;
        R1:      st_n = ovr ? HAZ : R2;
        R2:      st_n = ovr ? HAZ : R3;
        R3:      st_n = ovr ? HAZ : IDLE;
        default: st_n = IDLE;
      endcase
  end
  // lamp decode of the next state so the registered lamps line up with the state register
  always_comb begin
    l_n = (st_n == L1) ? 3'b001 : (st_n == L2) ? 3'b011 : (st_n == L3 || st_n == HAZ) ? 3'b111 : 3'b000;
    r_n = (st_n == R1) ? 3'b001 : (st_n == R2) ? 3'b011 : (st_n == R3 || st_n == HAZ) ? 3'b111 : 3'b000;
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st       <= IDLE;
      lights_l <= 3'b000;
      lights_r <= 3'b000;
      busy     <= 1'b0;
    end else begin
      st       <= st_n;
      lights_l <= l_n;
      lights_r <= r_n;
      busy     <= st_n != IDLE;
    end
endmodule

// File: doc/tbird_light_seq.md
Name: tbird_light_seq

Overview:
- Sequencer for the Thunderbird tail-light display.
- Owns a programmable prescaler that produces a one-cycle step strobe from the fast system clock.
- Runs a Moore FSM that advances only on that strobe, stepping the left and right three-lamp banks through the turn and hazard patterns.
- Sits between the switch/debounce inputs and the LED pins; it is the only block that drives the lamp outputs.

Parameters:
- TICK_DIV, 101, system-clock cycles per FSM step; legal range ≥1; 1 means step every cycle.
- CNT_W, 32, prescaler counter width; TICK_DIV-1 must fit in CNT_W bits.

Ports:
- clk  input  1  system clock, all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- left  input  1  left-turn request, level, already synchronous to clk.
- right  input  1  right-turn request, level, already synchronous to clk.
- hazard  input  1  hazard request, level, already synchronous to clk.
- lights_l  output  3  left lamps; bit0 = innermost (LA), bit2 = outermost (LC); registered.
- lights_r  output  3  right lamps; bit0 = innermost (RA), bit2 = outermost (RC); registered.
- busy  output  1  high whenever the FSM is not in IDLE; registered.
- tick  output  1  prescaler strobe; combinational decode of the counter.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - counter=0, state=IDLE, lights_l=000, lights_r=000, busy=0.
  - Outputs clear without waiting for a clock edge.
- Prescaler:
  - counter increments every cycle and free-runs from reset release; it is independent of the request inputs.
  - tick=1 exactly when counter==TICK_DIV-1; on that edge counter wraps to 0.
  - The first tick is high during the TICK_DIV-th cycle after reset deassertion; ticks then repeat with period TICK_DIV.
- FSM:
  - Eight states: IDLE, L1, L2, L3, R1, R2, R3, HAZ.
  - State changes only on an edge where tick=1; on all other edges it holds.
  - Requests are sampled only on tick edges, so pulses between ticks are ignored.
- Transitions on tick:
  - IDLE:
    - hazard=1, or left=1 and right=1 together → HAZ.
    - otherwise left=1 → L1.
    - otherwise right=1 → R1.
    - otherwise stay in IDLE.
  - L1→L2→L3→IDLE and R1→R2→R3→IDLE: a sequence, once started, completes even if its request drops.
  - Override: in any L/R state, hazard=1, or left=1 and right=1 together, goes to HAZ instead of the normal next state.
  - HAZ→IDLE unconditionally, which gives the on/off hazard flash.
- Output decode (Moore, registered with the state, so visible the cycle after the tick edge):
  - IDLE: l=000, r=000.
  - L1: l=001; L2: l=011; L3: l=111; r=000 in all three.
  - R1: r=001; R2: r=011; R3: r=111; l=000 in all three.
  - HAZ: l=111, r=111.
- Latency:
  - Request to first lamp: from 1 up to TICK_DIV cycles, depending on prescaler phase.
  - Step-to-step spacing: exactly TICK_DIV cycles.
- Illegal state encodings recover to IDLE on the next tick, with lamps 000 while in them.
- busy=1 in every state except IDLE.

Test Plan:
1. TICK_DIV=4. Assert reset mid-cycle with all requests idle → lights_l=lights_r=000 and busy=0 before the next edge. Release → tick high on cycles 3, 7, 11, … counting the first cycle after release as cycle 0.
2. TICK_DIV=4, left held from release → lights_l steps 001, 011, 111, 000 at 4-cycle spacing and then repeats; lights_r stays 000; busy is 0 only during the IDLE step.
3. TICK_DIV=4, right pulsed high for one cycle that includes a tick, then low → r=001, 011, 111, 000, then stays 000. Repeat with a one-cycle pulse that misses every tick → no response at all.
4. TICK_DIV=4, hazard held → l=r=111 and l=r=000 alternate every 4 cycles. Repeat with left and right held together → identical pattern.
5. TICK_DIV=4, left held, hazard raised while in L2 → next tick gives l=r=111 (HAZ), then IDLE, then L1 if only left remains.
6. TICK_DIV=1, left held → lights_l changes on every clock edge (001, 011, 111, 000, …). Assert reset while in L3 → outputs 000 immediately; after release the first step lands on cycle 0.
